// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage in front of a synchronous (1-cycle latency)
//   word-addressed program ROM. Owns the PC, issues one ROM read per cycle
//   while buffer credit allows, captures returned words into a 2-entry FIFO
//   and hands them to decode over a valid/ready handshake. A redirect flushes
//   everything in flight and restarts fetch at the target.
//
// Ports
//   clk             in   clock, rising edge
//   rst             in   synchronous active-high reset
//   rom_addr        out  ROM read address (always equals the PC register)
//   rom_data        in   ROM read data, one cycle after rom_addr
//   instr_valid     out  FIFO head holds an instruction
//   instr_ready     in   decode accepts the head this cycle
//   instr_data      out  head instruction word (zero when not valid)
//   instr_pc        out  head instruction word address (zero when not valid)
//   redirect_valid  in   redirect request (pulse or held)
//   redirect_pc     in   redirect target word address
//   stall_cnt       out  [INSTR_FETCH_STALL_CNT_EN only] saturating count of
//                        cycles with instr_valid=1 and instr_ready=0
//
// Optional feature macro: INSTR_FETCH_STALL_CNT_EN
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
`ifdef INSTR_FETCH_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_inflight;
  logic [ADDR_WIDTH-1:0] r_inflight_pc;

  logic [DATA_WIDTH-1:0] r_buf_data [2];
  logic [ADDR_WIDTH-1:0] r_buf_pc   [2];
  logic                  r_head;
  logic [1:0]            r_count;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic [1:0]            w_used;
  logic                  w_wr_idx;

  assign w_pop    = instr_valid & instr_ready;
  // Slots already committed: buffered words plus the read still in flight.
  assign w_used   = r_count + {1'b0, r_inflight};
  // A same-cycle pop frees a slot in time for the word this issue returns.
  assign w_issue  = !redirect_valid & ((w_used < 2'd2) | w_pop);
  assign w_push   = r_inflight & !redirect_valid;
  // Tail = head + count (mod 2); with count=2 the tail aliases the head,
  // which is only written when that head is being popped this cycle.
  assign w_wr_idx = r_head ^ r_count[0];

  assign rom_addr    = r_pc;
  assign instr_valid = (r_count != 2'd0);
  assign instr_data  = instr_valid ? r_buf_data[r_head] : '0;
  assign instr_pc    = instr_valid ? r_buf_pc[r_head]   : '0;

  // PC and in-flight tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect_valid) begin
      r_pc       <= redirect_pc;
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_pc          <= r_pc + ADDR_WIDTH'(1);
      r_inflight    <= 1'b1;
      r_inflight_pc <= r_pc;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  // Two-entry instruction buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= 1'b0;
      r_count <= 2'd0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_buf_data[i] <= '0;
        r_buf_pc[i]   <= '0;
      end
    end else if (redirect_valid) begin
      // Any pop this cycle has already been seen by decode; drop the rest.
      r_head  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_buf_data[w_wr_idx] <= rom_data;
        r_buf_pc[w_wr_idx]   <= r_inflight_pc;
      end
      r_head <= r_head ^ w_pop;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef INSTR_FETCH_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (instr_valid && !instr_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
`ifdef INSTR_FETCH_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  instr_fetch #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RESET_PC   (16'h0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef INSTR_FETCH_STALL_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ROM contents: mem[i] = 0x1000_0000 + i
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return 32'h1000_0000 + 32'(a);
  endfunction

  // Synchronous ROM, 1-cycle read latency
  initial rom_data = '0;
  always @(posedge clk) rom_data <= rom_word(rom_addr);

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] pc);
    exp_t e;
    e.pc   = pc;
    e.data = rom_word(pc);
    sb.push_back(e);
  endtask

  // Monitor: every accepted instruction must match the next scoreboard entry
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pop: got pc %0h data %0h, expected no transfer",
                 instr_pc, instr_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (instr_pc !== e.pc || instr_data !== e.data) begin
          n_fail++;
          $display("FAIL sb_pop: got pc %0h data %0h, expected pc %0h data %0h",
                   instr_pc, instr_data, e.pc, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  // Holds rst for one edge; returns at the start of cycle 0
  task automatic apply_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // ---- Streaming from reset, ready held high ----
    instr_ready = 1'b1;
    apply_reset();
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_addr", 64'(rom_addr), 64'h0);
    chk("rst_data", 64'(instr_data), 64'h0);
    chk("rst_pc", 64'(instr_pc), 64'h0);
    for (int i = 0; i < 10; i++) push_exp(16'(i));
    step();
    chk("fill_c1_valid", 64'(instr_valid), 64'd0);
    step();
    chk("first_valid", 64'(instr_valid), 64'd1);
    chk("first_pc", 64'(instr_pc), 64'h0);
    chk("first_data", 64'(instr_data), 64'h1000_0000);
    run_to(12);
    instr_ready = 1'b0;
    chk("stream_drain", 64'(sb.size()), 64'd0);

    // ---- Backpressure from cycle 0 for 10 cycles ----
    apply_reset();
    for (int i = 0; i < 4; i++) push_exp(16'(i));
    run_to(2);
    for (int c = 2; c < 10; c++) begin
      chk("bp_hold_pc", 64'(instr_pc), 64'h0);
      chk("bp_hold_data", 64'(instr_data), 64'h1000_0000);
      step();
    end
    chk("bp_addr", 64'(rom_addr), 64'h2);
    chk("bp_count_full", 64'(dut.r_count), 64'd2);
    instr_ready = 1'b1;
    run_to(14);
    instr_ready = 1'b0;
    chk("bp_drain", 64'(sb.size()), 64'd0);

    // ---- Redirect pulse in cycle 5 to 0x0040 ----
    instr_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 4; i++) push_exp(16'(i));
    push_exp(16'h0040);
    push_exp(16'h0041);
    push_exp(16'h0042);
    run_to(5);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    step();
    redirect_valid = 1'b0;
    chk("redir_t1_valid", 64'(instr_valid), 64'd0);
    step();
    chk("redir_t2_valid", 64'(instr_valid), 64'd0);
    step();
    chk("redir_t3_pc", 64'(instr_pc), 64'h0040);
    chk("redir_t3_data", 64'(instr_data), 64'h1000_0040);
    run_to(11);
    instr_ready = 1'b0;
    chk("redir_drain", 64'(sb.size()), 64'd0);

    // ---- Redirect to 0xFFFE, PC wrap ----
    apply_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    push_exp(16'hFFFE);
    push_exp(16'hFFFF);
    push_exp(16'h0000);
    push_exp(16'h0001);
    step();
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    chk("wrap_addr", 64'(rom_addr), 64'hFFFE);
    step();
    chk("wrap_c2_valid", 64'(instr_valid), 64'd0);
    step();
    chk("wrap_first_pc", 64'(instr_pc), 64'hFFFE);
    run_to(7);
    instr_ready = 1'b0;
    chk("wrap_drain", 64'(sb.size()), 64'd0);

    // ---- Reset mid-operation with word buffered and read in flight ----
    apply_reset();
    run_to(2);
    chk("mid_pre_valid", 64'(instr_valid), 64'd1);
    chk("mid_pre_inflight", 64'(dut.r_inflight), 64'd1);
    apply_reset();
    instr_ready = 1'b1;
    chk("mid_rst_valid", 64'(instr_valid), 64'd0);
    chk("mid_rst_addr", 64'(rom_addr), 64'h0);
    for (int i = 0; i < 3; i++) push_exp(16'(i));
    step();
    chk("mid_c1_valid", 64'(instr_valid), 64'd0);
    step();
    chk("mid_c2_pc", 64'(instr_pc), 64'h0);
    run_to(5);
    instr_ready = 1'b0;
    chk("mid_drain", 64'(sb.size()), 64'd0);

`ifdef INSTR_FETCH_STALL_CNT_EN
    // ---- Stall counter ----
    apply_reset();
    chk("stall_rst", 64'(stall_cnt), 64'd0);
    push_exp(16'h0000);
    run_to(9);
    chk("stall_7", 64'(stall_cnt), 64'd7);
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    step();
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    chk("stall_after_redir", 64'(stall_cnt), 64'd7);
    step();
    chk("stall_hold", 64'(stall_cnt), 64'd7);
    apply_reset();
    chk("stall_cleared", 64'(stall_cnt), 64'd0);
    chk("stall_drain", 64'(sb.size()), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
